pe_col_drain: RTL and testbench

PE_COL_DRAIN -- requirements
Module: pe_col_drain

---
 rtl/pe_drain_pkg.sv | 16 +
 rtl/pe_drain_fifo.sv | 64 ++++++
 rtl/pe_col_drain.sv | 134 +++++++++++++
 tb/tb_pe_col_drain.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_drain_pkg.sv
// Shared constants and types for the PE column drain: widths, saturation bounds, lane index.
package pe_drain_pkg;

  localparam int unsigned DBITS      = 32;
  localparam int unsigned LANES      = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned OUT_W      = 8;

  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  localparam int unsigned LANE_IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/pe_drain_fifo.sv
// Synchronous word FIFO for the drain path; drops a push when full and no pop coincides.
module pe_drain_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_c;
  logic             accept_c;
  logic [CW-1:0]    count_nxt;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_c    = out_valid && out_ready;
  assign accept_c = push && ((count < CW'(DEPTH)) || pop_c);
  assign out_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({accept_c, pop_c})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept_c) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_c) rd_ptr <= ptr_inc(rd_ptr);
      count     <= count_nxt;
      out_valid <= (count_nxt != '0);
      if (push && !accept_c) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/pe_col_drain.sv
// Drains a PE column: round/shift/saturate each result to 8 bits, pack lanes into words, buffer in a FIFO.
// Optional macro PE_DRAIN_RELU_EN clamps negative results to zero before saturation.
module pe_col_drain
  import pe_drain_pkg::*;
#(
  parameter int unsigned DBITS      = pe_drain_pkg::DBITS,
  parameter int unsigned LANES      = pe_drain_pkg::LANES,
  parameter int unsigned FIFO_DEPTH = pe_drain_pkg::FIFO_DEPTH
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [DBITS-1:0]                in_c,
  input  logic                            in_valid,
  input  logic [3:0]                      in_shift,
  input  logic                            in_propagate,
  output logic [8*LANES-1:0]              out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
  output logic                            overflow
);

  localparam int unsigned WORD_W = OUT_W * LANES;
  localparam int unsigned EXT_W  = DBITS + 1;

  logic             s1_valid;
  logic [DBITS-1:0] s1_c;
  logic [3:0]       s1_shift;
  logic             s1_prop;

  logic signed [EXT_W-1:0] ext_c;
  logic signed [EXT_W-1:0] bias_c;
  logic signed [EXT_W-1:0] shr_c;
  logic signed [EXT_W-1:0] relu_c;
  logic [OUT_W-1:0]        res_c;

  lane_idx_t         lane_idx;
  lane_idx_t         lane_nxt;
  logic              last_prop;
  logic              prop_nxt;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_nxt;
  logic              push_c;
  logic [WORD_W-1:0] push_word_c;

  // Stage 1: capture the raw tail result
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_c     <= '0;
      s1_shift <= '0;
      s1_prop  <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_c     <= in_c;
        s1_shift <= in_shift;
        s1_prop  <= in_propagate;
      end
    end
  end

  // Round-half-up arithmetic shift at DBITS+1 bits, then clamp to a signed byte
  always_comb begin
    ext_c  = EXT_W'($signed(s1_c));
    bias_c = '0;
    if (s1_shift != 4'd0) bias_c = EXT_W'(1) << (s1_shift - 4'd1);
    shr_c  = (ext_c + bias_c) >>> s1_shift;
`ifdef PE_DRAIN_RELU_EN
    relu_c = (shr_c < 0) ? '0 : shr_c;
`else
    relu_c = shr_c;
`endif
    if (relu_c > $signed(EXT_W'(SAT_MAX)))      res_c = OUT_W'(SAT_MAX);
    else if (relu_c < $signed(EXT_W'(SAT_MIN))) res_c = OUT_W'(SAT_MIN);
    else                                        res_c = relu_c[OUT_W-1:0];
  end

  // Packer: a tile change flushes a partial word; the last lane completes one
  always_comb begin
    word_nxt    = word_q;
    lane_nxt    = lane_idx;
    prop_nxt    = last_prop;
    push_c      = 1'b0;
    push_word_c = '0;
    if (s1_valid) begin
      prop_nxt = s1_prop;
      if ((s1_prop != last_prop) && (lane_idx != '0)) begin
        push_c                = 1'b1;
        push_word_c           = word_q;
        word_nxt              = '0;
        word_nxt[OUT_W-1:0]   = res_c;
        lane_nxt              = lane_idx_t'(1);
      end else if (lane_idx == lane_idx_t'(LANES - 1)) begin
        push_c                                      = 1'b1;
        push_word_c                                 = word_q;
        push_word_c[int'(lane_idx)*OUT_W +: OUT_W]  = res_c;
        word_nxt                                    = '0;
        lane_nxt                                    = '0;
      end else begin
        word_nxt[int'(lane_idx)*OUT_W +: OUT_W] = res_c;
        lane_nxt                                = lane_idx + lane_idx_t'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      word_q    <= '0;
      lane_idx  <= '0;
      last_prop <= 1'b0;
    end else begin
      word_q    <= word_nxt;
      lane_idx  <= lane_nxt;
      last_prop <= prop_nxt;
    end
  end

  pe_drain_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (push_c),
    .push_data (push_word_c),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .count     (fifo_count),
    .overflow  (overflow)
  );

endmodule

// File: tb/tb_pe_col_drain.sv
// Randomized self-checking bench for pe_col_drain against a queue-based behavioural model.
module tb_pe_col_drain;

  localparam int unsigned LANES      = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  logic        CLK;
  logic        RST;
  logic [31:0] in_c;
  logic        in_valid;
  logic [3:0]  in_shift;
  logic        in_propagate;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0]  cur_q[$];
  logic [31:0] exp_q[$];
  logic        m_last   = 1'b0;
  logic        m_ovf    = 1'b0;
  logic        stalled  = 1'b0;
  logic        cur_prop = 1'b0;

  pe_col_drain dut (
    .CLK          (CLK),
    .RST          (RST),
    .in_c         (in_c),
    .in_valid     (in_valid),
    .in_shift     (in_shift),
    .in_propagate (in_propagate),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_res(input int c, input int sh);
    longint r;
    r = longint'(c);
    if (sh > 0) r = r + (longint'(1) <<< (sh - 1));
    r = r >>> sh;
`ifdef PE_DRAIN_RELU_EN
    if (r < 0) r = 0;
`endif
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return 8'(r);
  endfunction

  task automatic model_emit();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < cur_q.size(); i++) w[8*i +: 8] = cur_q[i];
    cur_q.delete();
    if (stalled && exp_q.size() >= FIFO_DEPTH) m_ovf = 1'b1;
    else exp_q.push_back(w);
  endtask

  task automatic model_push(input int c, input int sh, input logic p);
    if ((p != m_last) && (cur_q.size() > 0)) model_emit();
    cur_q.push_back(model_res(c, sh));
    m_last = p;
    if (cur_q.size() == LANES) model_emit();
  endtask

  task automatic model_reset();
    cur_q.delete();
    exp_q.delete();
    m_last = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic send(input int c, input int sh, input logic p);
    in_c         = c;
    in_shift     = 4'(sh);
    in_propagate = p;
    in_valid     = 1'b1;
    model_push(c, sh, p);
    @(posedge CLK);
    #1;
    in_valid     = 1'b0;
    in_c         = $urandom;
    in_shift     = 4'($urandom);
    in_propagate = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_drain(input string tag);
    int budget;
    budget = 60;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      @(posedge CLK);
      #1;
      budget--;
    end
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // Output scoreboard: every accepted word must match the model's next word
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      check("word_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    logic [31:0] rc;
    RST          = 1'b1;
    in_c         = '0;
    in_valid     = 1'b0;
    in_shift     = '0;
    in_propagate = 1'b0;
    out_ready    = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_out_valid",  64'(out_valid),  64'(0));
    check("rst_out_data",   64'(out_data),   64'(0));
    check("rst_fifo_count", 64'(fifo_count), 64'(0));
    check("rst_overflow",   64'(overflow),   64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(2);

    // Basic packing and latency
    send(5, 0, 1'b0);
    send(-3, 0, 1'b0);
    send(127, 0, 1'b0);
    send(-128, 0, 1'b0);
    @(negedge CLK);
    check("latency_not_yet", 64'(out_valid), 64'(0));
    @(negedge CLK);
    check("latency_valid", 64'(out_valid), 64'(1));
    check("basic_word", 64'(out_data), 64'(32'h807FFD05));
    wait_drain("basic_drain");

    // Rounding and saturation corners
    send(23, 2, 1'b0);
    send(-6, 2, 1'b0);
    send(1000, 0, 1'b0);
    send(-1000, 0, 1'b0);
    wait_drain("round_sat_drain");

    // Tile change flushes a partial word
    send(1, 0, 1'b0);
    send(2, 0, 1'b0);
    send(3, 0, 1'b1);
    send(4, 0, 1'b1);
    send(5, 0, 1'b1);
    send(6, 0, 1'b1);
    wait_drain("tile_flush_drain");
    cur_prop = 1'b1;

`ifdef PE_DRAIN_RELU_EN
    send(-5, 0, cur_prop);
    send(7, 0, cur_prop);
    send(-1, 0, cur_prop);
    send(200, 0, cur_prop);
    wait_drain("relu_drain");
`endif

    // Randomized traffic with occasional tile changes and idle cycles
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        case ($urandom_range(0, 2))
          0:       rc = 32'($urandom_range(0, 600)) - 32'd300;
          1:       rc = 32'($urandom_range(0, 200000)) - 32'd100000;
          default: rc = $urandom;
        endcase
        if ($urandom_range(0, 9) == 0) cur_prop = ~cur_prop;
        send(int'(rc), int'($urandom_range(0, 15)), cur_prop);
      end
    end
    while (cur_q.size() != 0) send(int'($urandom_range(0, 255)), 0, cur_prop);
    wait_drain("random_drain");
    idle(3);
    check("idle_count", 64'(fifo_count), 64'(0));

    // Overflow: five words into a stalled four-entry FIFO
    out_ready = 1'b0;
    stalled   = 1'b1;
    for (int i = 0; i < 5 * LANES; i++) send(i * 3 - 20, 0, cur_prop);
    idle(4);
    check("ovf_count", 64'(fifo_count), 64'(FIFO_DEPTH));
    check("ovf_flag", 64'(overflow), 64'(m_ovf));
    check("ovf_flag_set", 64'(overflow), 64'(1));
    check("ovf_valid", 64'(out_valid), 64'(1));
    check("ovf_model_words", 64'(exp_q.size()), 64'(FIFO_DEPTH));
    out_ready = 1'b1;
    stalled   = 1'b0;
    wait_drain("ovf_drain");
    idle(3);
    check("ovf_empty_count", 64'(fifo_count), 64'(0));
    check("ovf_empty_valid", 64'(out_valid), 64'(0));
    check("ovf_sticky", 64'(overflow), 64'(1));

    // Reset mid-word discards partial lanes
    send(9, 0, 1'b0);
    send(8, 0, 1'b0);
    idle(3);
    RST = 1'b1;
    model_reset();
    @(negedge CLK);
    check("mid_rst_out_valid",  64'(out_valid),  64'(0));
    check("mid_rst_out_data",   64'(out_data),   64'(0));
    check("mid_rst_fifo_count", 64'(fifo_count), 64'(0));
    check("mid_rst_overflow",   64'(overflow),   64'(0));
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(1);
    send(1, 0, 1'b0);
    send(2, 0, 1'b0);
    send(3, 0, 1'b0);
    send(4, 0, 1'b0);
    @(negedge CLK);
    @(negedge CLK);
    check("post_rst_valid", 64'(out_valid), 64'(1));
    check("post_rst_word", 64'(out_data), 64'(32'h04030201));
    wait_drain("post_rst_drain");
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
